// File: rtl/regfile_init_sb.sv
// Parametrised register file with two async read ports, one write port, write-first bypass,
// a power-up init sequencer (REG[i] = i) and a pending-write scoreboard. Define
// REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_init_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              ready
);

  typedef enum logic {INIT, RUN} stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] initCnt, nextCnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  sb, sbNext;
  logic              running, wrEff, issEff, bypass1, bypass2;
  logic              wrZero, issZero, rdZero1, rdZero2;

`ifdef REGFILE_ZERO_REG_EN
  assign wrZero  = (wr_addr == '0);
  assign issZero = (iss_addr == '0);
  assign rdZero1 = (rd_addr1 == '0);
  assign rdZero2 = (rd_addr2 == '0);
`else
  assign wrZero  = 1'b0;
  assign issZero = 1'b0;
  assign rdZero1 = 1'b0;
  assign rdZero2 = 1'b0;
`endif

  assign running = (state == RUN);
  assign ready   = running;
  assign wrEff   = running && wr_en && !wrZero;
  assign issEff  = running && iss_en && !issZero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      initCnt <= '0;
    end else begin
      state   <= nextState;
      initCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = initCnt;
    case (state)
      INIT: begin
        nextCnt = initCnt + 1'b1;
        if (initCnt == ADDR_W'(DEPTH - 1)) nextState = RUN;
      end
      RUN: ;
      default: nextState = INIT;
    endcase
  end

  // Storage has no reset; the init sequencer owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (!running) regs[initCnt] <= DATA_W'(initCnt);
    else if (wrEff) regs[wr_addr] <= wr_data;
  end

  // A same-address issue overrides the writeback clear: a newer producer is in flight.
  always_comb begin
    sbNext = sb;
    if (wrEff) sbNext[wr_addr] = 1'b0;
    if (issEff) sbNext[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else sb <= sbNext;
  end

  assign bypass1 = wrEff && (wr_addr == rd_addr1);
  assign bypass2 = wrEff && (wr_addr == rd_addr2);

  always_comb begin
    rd_data1 = bypass1 ? wr_data : regs[rd_addr1];
    rd_data2 = bypass2 ? wr_data : regs[rd_addr2];
    if (rdZero1) rd_data1 = '0;
    if (rdZero2) rd_data2 = '0;
    rd_pend1 = sb[rd_addr1] && !bypass1 && !rdZero1;
    rd_pend2 = sb[rd_addr2] && !bypass2 && !rdZero2;
  end

endmodule
